// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Parametrised pipeline stage register used between the IF/ID, ID/EX,
// EX/MEM and MEM/WB boundaries. Carries an opaque payload plus a control
// vector under a valid/ready handshake. It supports bubble (NOP slot)
// insertion for load-use hazards and flush for branch/jump redirects.
// An optional skid register decouples in_ready from out_ready. Saturating
// counters record inserted bubbles and output stall cycles.
//
// Parameters:
//   DATA_W - payload width
//   CTRL_W - control vector width
//   SKID   - 1: main + skid register, 0: main register only
//   CNT_W  - statistics counter width
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - upstream handshake
//   in_data/in_ctrl       - upstream payload and control
//   bubble                - insert a NOP slot, hold upstream
//   flush                 - discard every word held in the stage
//   out_valid/out_ready   - downstream handshake
//   out_data/out_ctrl     - registered payload/control, zero when invalid
//   bubble_cnt, stall_cnt - saturating statistics counters

module pipe_stage_reg #(
    parameter int DATA_W = 165,
    parameter int CTRL_W = 13,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit HasSkid = (SKID != 0);

    logic              mValid_q, mValid_d;
    logic [DATA_W-1:0] mData_q,  mData_d;
    logic [CTRL_W-1:0] mCtrl_q,  mCtrl_d;
    logic              sValid_q, sValid_d;
    logic [DATA_W-1:0] sData_q,  sData_d;
    logic [CTRL_W-1:0] sCtrl_q,  sCtrl_d;
    logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
    logic [CNT_W-1:0]  stallCnt_q,  stallCnt_d;

    logic adv;
    logic inReady;

    // The main register may advance when it is empty or when downstream
    // takes its word. With a skid register present, in_ready is derived
    // from the skid occupancy only, so out_ready never reaches in_ready.
    always_comb begin
        adv = !mValid_q || out_ready;
        if (flush) begin
            inReady = 1'b1;
        end else if (HasSkid) begin
            inReady = !sValid_q && !bubble;
        end else begin
            inReady = adv && !bubble;
        end
    end

    // Next-state selection. Flush beats everything; a waiting skid word is
    // drained before a bubble slot so word order is kept and the bubble is
    // simply postponed. Payloads are zeroed whenever a slot goes invalid so
    // the outputs read as zero without any output masking.
    always_comb begin
        mValid_d    = mValid_q;
        mData_d     = mData_q;
        mCtrl_d     = mCtrl_q;
        sValid_d    = sValid_q;
        sData_d     = sData_q;
        sCtrl_d     = sCtrl_q;
        bubbleCnt_d = bubbleCnt_q;
        stallCnt_d  = stallCnt_q;

        if (flush) begin
            mValid_d = 1'b0;
            mData_d  = '0;
            mCtrl_d  = '0;
            sValid_d = 1'b0;
            sData_d  = '0;
            sCtrl_d  = '0;
        end else if (adv) begin
            if (HasSkid && sValid_q) begin
                mValid_d = 1'b1;
                mData_d  = sData_q;
                mCtrl_d  = sCtrl_q;
                sValid_d = 1'b0;
                sData_d  = '0;
                sCtrl_d  = '0;
            end else if (bubble) begin
                mValid_d = 1'b0;
                mData_d  = '0;
                mCtrl_d  = '0;
                if (bubbleCnt_q != {CNT_W{1'b1}}) begin
                    bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
                end
            end else if (in_valid) begin
                mValid_d = 1'b1;
                mData_d  = in_data;
                mCtrl_d  = in_ctrl;
            end else begin
                mValid_d = 1'b0;
                mData_d  = '0;
                mCtrl_d  = '0;
            end
        end else if (HasSkid && in_valid && inReady) begin
            sValid_d = 1'b1;
            sData_d  = in_data;
            sCtrl_d  = in_ctrl;
        end

        if (mValid_q && !out_ready && !flush &&
            (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mValid_q    <= 1'b0;
            mData_q     <= '0;
            mCtrl_q     <= '0;
            sValid_q    <= 1'b0;
            sData_q     <= '0;
            sCtrl_q     <= '0;
            bubbleCnt_q <= '0;
            stallCnt_q  <= '0;
        end else begin
            mValid_q    <= mValid_d;
            mData_q     <= mData_d;
            mCtrl_q     <= mCtrl_d;
            sValid_q    <= sValid_d;
            sData_q     <= sData_d;
            sCtrl_q     <= sCtrl_d;
            bubbleCnt_q <= bubbleCnt_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign in_ready   = inReady;
    assign out_valid  = mValid_q;
    assign out_data   = mData_q;
    assign out_ctrl   = mCtrl_q;
    assign bubble_cnt = bubbleCnt_q;
    assign stall_cnt  = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Drives a skid-equipped stage (16-bit counters) and a skid-less stage
// (2-bit counters) with identical stimulus and compares both against a
// slot-queue reference model every cycle.

module tb_pipe_stage_reg;

    localparam int DW = 40;
    localparam int CW = 13;
    localparam int WW = DW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          inValid;
    logic [DW-1:0] inData;
    logic [CW-1:0] inCtrl;
    logic          bubble;
    logic          flush;
    logic          outReady;

    logic          inReady0, inReady1;
    logic          outValid0, outValid1;
    logic [DW-1:0] outData0, outData1;
    logic [CW-1:0] outCtrl0, outCtrl1;
    logic [15:0]   bubbleCnt0, stallCnt0;
    logic [1:0]    bubbleCnt1, stallCnt1;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady0),
        .in_data(inData), .in_ctrl(inCtrl),
        .bubble(bubble), .flush(flush),
        .out_valid(outValid0), .out_ready(outReady),
        .out_data(outData0), .out_ctrl(outCtrl0),
        .bubble_cnt(bubbleCnt0), .stall_cnt(stallCnt0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady1),
        .in_data(inData), .in_ctrl(inCtrl),
        .bubble(bubble), .flush(flush),
        .out_valid(outValid1), .out_ready(outReady),
        .out_data(outData1), .out_ctrl(outCtrl1),
        .bubble_cnt(bubbleCnt1), .stall_cnt(stallCnt1)
    );

    // Reference model: each stage is a queue of slots, front slot = output.
    // A slot is either a real word or a bubble marker.
    int          qn [2];
    logic [WW-1:0] qw [2][2];
    bit          qb [2][2];
    int unsigned bCnt [2];
    int unsigned sCnt [2];
    int unsigned cntMax [2];
    bit          hasSkid [2];

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit modelAdv(int k);
        return (qn[k] == 0) || qb[k][0] || outReady;
    endfunction

    function automatic bit modelInReady(int k);
        if (flush) return 1'b1;
        if (hasSkid[k]) return (qn[k] < 2) && !bubble;
        return modelAdv(k) && !bubble;
    endfunction

    task automatic modelStep(int k);
        bit a, acc;
        if (rst) begin
            qn[k] = 0; bCnt[k] = 0; sCnt[k] = 0;
            return;
        end
        a   = modelAdv(k);
        acc = inValid && modelInReady(k);
        if (qn[k] > 0 && !qb[k][0] && !outReady && !flush && sCnt[k] < cntMax[k]) sCnt[k]++;
        if (flush) begin
            qn[k] = 0;
            return;
        end
        if (a && qn[k] > 0) begin
            qw[k][0] = qw[k][1];
            qb[k][0] = qb[k][1];
            qn[k]--;
        end
        if (bubble && a && qn[k] == 0) begin
            qb[k][0] = 1'b1;
            qw[k][0] = '0;
            qn[k]    = 1;
            if (bCnt[k] < cntMax[k]) bCnt[k]++;
        end else if (acc) begin
            qw[k][qn[k]] = {inCtrl, inData};
            qb[k][qn[k]] = 1'b0;
            qn[k]++;
        end
    endtask

    task automatic checkInst(int k);
        bit            expValid;
        logic [WW-1:0] expWord;
        expValid = (qn[k] > 0) && !qb[k][0];
        expWord  = expValid ? qw[k][0] : '0;
        if (k == 0) begin
            checkOutput("u0.out_valid", 64'(outValid0), 64'(expValid));
            checkOutput("u0.out_data", 64'(outData0), 64'(expWord[DW-1:0]));
            checkOutput("u0.out_ctrl", 64'(outCtrl0), 64'(expWord[WW-1:DW]));
            checkOutput("u0.in_ready", 64'(inReady0), 64'(modelInReady(0)));
            checkOutput("u0.bubble_cnt", 64'(bubbleCnt0), 64'(bCnt[0]));
            checkOutput("u0.stall_cnt", 64'(stallCnt0), 64'(sCnt[0]));
        end else begin
            checkOutput("u1.out_valid", 64'(outValid1), 64'(expValid));
            checkOutput("u1.out_data", 64'(outData1), 64'(expWord[DW-1:0]));
            checkOutput("u1.out_ctrl", 64'(outCtrl1), 64'(expWord[WW-1:DW]));
            checkOutput("u1.in_ready", 64'(inReady1), 64'(modelInReady(1)));
            checkOutput("u1.bubble_cnt", 64'(bubbleCnt1), 64'(bCnt[1]));
            checkOutput("u1.stall_cnt", 64'(stallCnt1), 64'(sCnt[1]));
        end
    endtask

    // One cycle: drive inputs, check settled outputs just before the edge,
    // then advance the model across the edge.
    task automatic applyStimulus(input bit r, input bit iv, input logic [DW-1:0] d,
                                 input logic [CW-1:0] c, input bit b, input bit f, input bit ordy);
        rst = r; inValid = iv; inData = d; inCtrl = c;
        bubble = b; flush = f; outReady = ordy;
        #3;
        if (!rst) begin
            checkInst(0);
            checkInst(1);
        end
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    initial begin
        cntMax[0] = 65535; cntMax[1] = 3;
        hasSkid[0] = 1'b1; hasSkid[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            qn[k] = 0; bCnt[k] = 0; sCnt[k] = 0;
        end
        rst = 1'b1; inValid = 1'b0; inData = '0; inCtrl = '0;
        bubble = 1'b0; flush = 1'b0; outReady = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Streaming at full throughput.
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, DW'(i), CW'(i), 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Backpressure then release.
        for (int i = 1; i <= 3; i++) applyStimulus(0, 1, DW'(i), CW'(i), 0, 0, 0);
        applyStimulus(0, 1, 3, 3, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Bubble mid-stream.
        applyStimulus(0, 1, 5, 5, 0, 0, 1);
        applyStimulus(0, 1, 6, 6, 0, 0, 1);
        applyStimulus(0, 1, 7, 7, 1, 0, 1);
        applyStimulus(0, 1, 7, 7, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Flush with main and skid occupied.
        applyStimulus(0, 1, 4, 4, 0, 0, 0);
        applyStimulus(0, 1, 5, 5, 0, 0, 0);
        applyStimulus(0, 1, 6, 6, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Counter saturation on the narrow instance, then reset.
        applyStimulus(0, 1, 9, 9, 0, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(1, 1, 11, 11, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 9) < 7),
                          DW'({$urandom, $urandom}),
                          CW'($urandom),
                          ($urandom_range(0, 99) < 15),
                          ($urandom_range(0, 99) < 5),
                          ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
